ascon_round_ctrl: RTL
=====================

Name: ascon_round_ctrl

Overview:
- Sequences the Ascon permutation round datapath (constant addition, substitution, linear layer) for 6, 8 or 12 rounds.
- Owns the 320-bit permutation state register.
- Drives the round counter and the round-count selector into the datapath.
- Sits between the mode FSM (init/absorb/squeeze/finalise) and the combinational round logic; exposes a start/ready/done handshake.

Parameters:
- STATE_W, 320, permutation state width in bits.
- CTR_W, 5, width of round counter and round-count fields.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a permutation; sampled only when ready=1.
- rounds_in  input  CTR_W  requested round count; legal values 6, 8, 12.
- state_in  input  STATE_W  initial state, loaded on accepted start.
- round_in  input  STATE_W  combinational datapath result for the current state_q/ctr.
- ready  output  1  high in IDLE only.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse; state_q holds the final permutation result.
- err  output  1  one-cycle pulse on rejected start (illegal rounds_in).
- ctr  output  CTR_W  round index to the datapath: 1..rounds_q during RUN, 0 otherwise.
- rounds  output  CTR_W  latched round count to the datapath.
- state_q  output  STATE_W  state register; feeds the datapath and the mode FSM.

Behaviour:
- Clock and reset: one clock domain. clk is the only clock; rst is asynchronous and active-high.
- Reset values: FSM=IDLE, ctr=0, rounds=0, state_q=0, done=0, err=0, busy=0, ready=1.
- Reset asserted mid-run aborts immediately to the reset values. No done is issued.
- FSM states: IDLE, RUN, DONE. ready=(IDLE); busy=(RUN). done and err are registered.
- IDLE with start=1 and rounds_in in {6,8,12}:
  - state_q<=state_in, rounds<=rounds_in, ctr<=1.
  - Next state RUN.
- IDLE with start=1 and rounds_in illegal (0, 7, 13, …):
  - err<=1 for exactly one cycle; state stays IDLE.
  - state_q, rounds and ctr are unchanged.
- RUN, every cycle:
  - state_q<=round_in.
  - If ctr==rounds: ctr<=0, done<=1, next DONE.
  - Else: ctr<=ctr+1.
  - ctr never exceeds rounds and never wraps.
- DONE: done deasserts, next IDLE. state_q holds the result until the next accepted start.
- Latency, start accepted at edge of cycle 0:
  - RUN occupies cycles 1..R.
  - done is high in cycle R+1.
  - ready is high again in cycle R+2.
  - Throughput: one permutation per R+2 cycles.
- start during RUN or DONE is ignored: no err, no reload. The requester must hold start until it sees ready.
- rounds_in and state_in changing during RUN have no effect, because both are latched at accept.
- ctr=0 outside RUN. The datapath output is undefined for ctr=0, and round_in is not sampled outside RUN.
- The round constant for ctr=k is 0xF0−15·(k−1+12−rounds), applied in the datapath. The controller only guarantees the ctr/rounds pairing.

Test Plan:
- Round-count 12: stub datapath round_in=state_q+1; start with rounds_in=12, state_in=0x100.
  - ctr steps 1,2,…,12 in cycles 1..12.
  - done high in cycle 13 only, with state_q=0x10C.
  - ready high in cycle 14.
- Round-count 6 and 8: same stub, state_in=0.
  - done in cycle 7 with state_q=6, and in cycle 9 with state_q=8.
  - rounds output equals 6 and 8 respectively throughout RUN.
- Illegal rounds_in=7 (then 0), state_q preloaded to 0xABC:
  - err pulses one cycle; ready stays 1; busy never asserts.
  - state_q remains 0xABC; ctr remains 0.
- start held high through a 12-round run, with rounds_in switched to 6 and state_in switched at cycle 5:
  - No err; the run still completes 12 rounds.
  - A second permutation is accepted in the first ready cycle (cycle 14) with the new values.
- Reset asserted asynchronously mid-cycle at ctr=4 of a 12-round run:
  - Outputs return to reset values immediately, without waiting for a clock edge.
  - No done pulse appears.
  - After release, a fresh 8-round start completes normally.

Source files
------------

// File: rtl/ascon_round_ctrl.sv
// rtl/ascon_round_ctrl.sv - Ascon permutation round sequencer owning the 320-bit state register
module ascon_round_ctrl #(
   parameter int STATE_W = 320,
   parameter int CTR_W   = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [CTR_W-1:0]   rounds_in,
   input  logic [STATE_W-1:0] state_in,
   input  logic [STATE_W-1:0] round_in,
   output logic               ready,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [CTR_W-1:0]   ctr,
   output logic [CTR_W-1:0]   rounds,
   output logic [STATE_W-1:0] state_q
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } fsm_t;

   fsm_t fsm, fsm_next;
   logic legal;
   logic accept;
   logic reject;
   logic last;

   assign legal = (rounds_in == CTR_W'(6)) || (rounds_in == CTR_W'(8)) ||
                  (rounds_in == CTR_W'(12));
   assign last  = (ctr == rounds);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) fsm <= IDLE;
      else     fsm <= fsm_next;
   end

   always_comb begin
      fsm_next = fsm;
      accept   = 1'b0;
      reject   = 1'b0;
      unique case (fsm)
         IDLE: begin
            if (start && legal) begin
               accept   = 1'b1;
               fsm_next = RUN;
            end else if (start) begin
               reject   = 1'b1;
            end
         end
         RUN:     if (last) fsm_next = FIN;
         FIN:     fsm_next = IDLE;
         default: fsm_next = IDLE;
      endcase
   end

   // Round index and state advance together; the final round clears ctr and raises done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctr     <= '0;
         rounds  <= '0;
         state_q <= '0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= reject;
         if (accept) begin
            state_q <= state_in;
            rounds  <= rounds_in;
            ctr     <= CTR_W'(1);
         end else if (fsm == RUN) begin
            state_q <= round_in;
            if (last) begin
               ctr  <= '0;
               done <= 1'b1;
            end else begin
               ctr  <= ctr + CTR_W'(1);
            end
         end
      end
   end

   assign ready = (fsm == IDLE);
   assign busy  = (fsm == RUN);

endmodule
